// File: rtl/a2mem_switch_snoop.sv
// Apple II bus snooper: tracks video, ][e aux, slot-ROM and IIgs soft switches, the keyboard latch
// and main/aux classification of each strobed RAM access. All outputs are registered.
module a2mem_switch_snoop #(
    parameter bit ENABLE_IIE  = 1'b1,
    parameter bit ENABLE_IIGS = 1'b1
) (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        rw_n,
    input  logic        data_strobe,

    output logic        TEXT_MODE,
    output logic        MIXED_MODE,
    output logic        PAGE2,
    output logic        HIRES_MODE,
    output logic        AN0,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,

    output logic        STORE80,
    output logic        RAMRD,
    output logic        RAMWRT,
    output logic        INTCXROM,
    output logic        ALTZP,
    output logic        SLOTC3ROM,
    output logic        COL80,
    output logic        ALTCHAR,

    output logic        INTC8ROM,
    output logic [2:0]  SLOTROM,

    output logic [3:0]  TEXT_COLOR,
    output logic [3:0]  BACKGROUND_COLOR,
    output logic [3:0]  BORDER_COLOR,
    output logic        MONOCHROME_MODE,
    output logic        MONOCHROME_DHIRES_MODE,
    output logic        SHRG_MODE,
    output logic        LINEARIZE_MODE,

    output logic        aux_mem,
    output logic [7:0]  keycode,
    output logic        keypress_strobe
);

    // Bit positions inside the packed switch vectors; order matches the even/odd address pairs.
    localparam int VID_TEXT  = 0;
    localparam int VID_MIXED = 1;
    localparam int VID_PAGE2 = 2;
    localparam int VID_HIRES = 3;

    localparam int IIE_STORE80   = 0;
    localparam int IIE_RAMRD     = 1;
    localparam int IIE_RAMWRT    = 2;
    localparam int IIE_INTCXROM  = 3;
    localparam int IIE_ALTZP     = 4;
    localparam int IIE_SLOTC3ROM = 5;

    localparam logic [7:0] VID_RESET = 8'h01;

    // Main/aux selection using the switch state as it stood before the current access.
    function automatic logic aux_select(
        input logic [15:0] a,
        input logic        rd,
        input logic [7:0]  vid,
        input logic [7:0]  iie
    );
        logic sel;
        if (a[15:9] == 7'd0) begin
            sel = iie[IIE_ALTZP];
        end else if ((a[15:10] == 6'b000001) && iie[IIE_STORE80]) begin
            sel = vid[VID_PAGE2];
        end else if ((a[15:13] == 3'b001) && iie[IIE_STORE80] && vid[VID_HIRES]) begin
            sel = vid[VID_PAGE2];
        end else if (a < 16'hC000) begin
            sel = rd ? iie[IIE_RAMRD] : iie[IIE_RAMWRT];
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

    logic [7:0] vid_sw_r;
    logic [7:0] iie_sw_r;
    logic       intc8_r;
    logic [2:0] slotrom_r;
    logic [3:0] text_color_r;
    logic [3:0] bg_color_r;
    logic [3:0] border_color_r;
    logic       mono_r;
    logic       mono_dhr_r;
    logic       shrg_r;
    logic       linear_r;
    logic       aux_r;
    logic [7:0] keycode_r;
    logic       kstb_r;

    logic [7:0] vid_sw_s;
    logic [7:0] iie_sw_s;
    logic       intc8_s;
    logic [2:0] slotrom_s;
    logic [3:0] text_color_s;
    logic [3:0] bg_color_s;
    logic [3:0] border_color_s;
    logic       mono_s;
    logic       mono_dhr_s;
    logic       shrg_s;
    logic       linear_s;
    logic       aux_s;
    logic [7:0] keycode_s;
    logic       kstb_s;

    logic       is_c00x_s;
    logic       is_c01x_s;
    logic       is_c05x_s;
    logic       is_cfff_s;
    logic       is_slot_s;
    logic [3:0] slot_n_s;

    // Address decode of the soft-switch and slot-ROM windows.
    always_comb begin
        slot_n_s  = addr[11:8];
        is_c00x_s = (addr[15:4] == 12'hC00);
        is_c01x_s = (addr[15:4] == 12'hC01);
        is_c05x_s = (addr[15:4] == 12'hC05);
        is_cfff_s = (addr == 16'hCFFF);
        is_slot_s = (addr[15:12] == 4'hC) && (slot_n_s >= 4'd1) && (slot_n_s <= 4'd7);
    end

    // Next-state evaluation: every field holds unless a qualified strobe touches it.
    always_comb begin
        vid_sw_s       = vid_sw_r;
        iie_sw_s       = iie_sw_r;
        intc8_s        = intc8_r;
        slotrom_s      = slotrom_r;
        text_color_s   = text_color_r;
        bg_color_s     = bg_color_r;
        border_color_s = border_color_r;
        mono_s         = mono_r;
        mono_dhr_s     = mono_dhr_r;
        shrg_s         = shrg_r;
        linear_s       = linear_r;
        aux_s          = aux_r;
        keycode_s      = keycode_r;
        kstb_s         = 1'b0;

        if (data_strobe) begin
            aux_s = aux_select(addr, rw_n, vid_sw_r, iie_sw_r);

            if (is_c05x_s) begin
                vid_sw_s[addr[3:1]] = addr[0];
            end else begin
                vid_sw_s = vid_sw_r;
            end

            if (ENABLE_IIE && is_c00x_s && !rw_n) begin
                iie_sw_s[addr[3:1]] = addr[0];
            end else begin
                iie_sw_s = iie_sw_r;
            end

            // Rising edge of the key-available bit produces the one-clock keypress pulse.
            if (is_c00x_s && rw_n) begin
                keycode_s = data;
                kstb_s    = data[7] & ~keycode_r[7];
            end else if (is_c01x_s) begin
                keycode_s[7] = 1'b0;
            end else begin
                keycode_s = keycode_r;
            end

            if (is_cfff_s) begin
                intc8_s   = 1'b0;
                slotrom_s = 3'd0;
            end else if (is_slot_s && !iie_sw_r[IIE_INTCXROM]) begin
                if ((slot_n_s == 4'd3) && !iie_sw_r[IIE_SLOTC3ROM]) begin
                    intc8_s = 1'b1;
                end else if (!intc8_r) begin
                    slotrom_s = slot_n_s[2:0];
                end else begin
                    slotrom_s = slotrom_r;
                end
            end else begin
                intc8_s = intc8_r;
            end

            if (ENABLE_IIGS && !rw_n) begin
                case (addr)
                    16'hC021: mono_s = data[7];
                    16'hC022: begin
                        text_color_s = data[7:4];
                        bg_color_s   = data[3:0];
                    end
                    16'hC029: begin
                        shrg_s     = data[7];
                        linear_s   = data[6];
                        mono_dhr_s = data[5];
                    end
                    16'hC034: border_color_s = data[3:0];
                    default: mono_s = mono_r;
                endcase
            end else begin
                mono_s = mono_r;
            end
        end else begin
            aux_s = aux_r;
        end
    end

    // State registers with synchronous reset that overrides any coincident strobe.
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            vid_sw_r       <= VID_RESET;
            iie_sw_r       <= 8'h00;
            intc8_r        <= 1'b0;
            slotrom_r      <= 3'd0;
            text_color_r   <= 4'hF;
            bg_color_r     <= 4'h6;
            border_color_r <= 4'h6;
            mono_r         <= 1'b0;
            mono_dhr_r     <= 1'b0;
            shrg_r         <= 1'b0;
            linear_r       <= 1'b0;
            aux_r          <= 1'b0;
            keycode_r      <= 8'h00;
            kstb_r         <= 1'b0;
        end else begin
            vid_sw_r       <= vid_sw_s;
            iie_sw_r       <= iie_sw_s;
            intc8_r        <= intc8_s;
            slotrom_r      <= slotrom_s;
            text_color_r   <= text_color_s;
            bg_color_r     <= bg_color_s;
            border_color_r <= border_color_s;
            mono_r         <= mono_s;
            mono_dhr_r     <= mono_dhr_s;
            shrg_r         <= shrg_s;
            linear_r       <= linear_s;
            aux_r          <= aux_s;
            keycode_r      <= keycode_s;
            kstb_r         <= kstb_s;
        end
    end

    assign TEXT_MODE  = vid_sw_r[0];
    assign MIXED_MODE = vid_sw_r[1];
    assign PAGE2      = vid_sw_r[2];
    assign HIRES_MODE = vid_sw_r[3];
    assign AN0        = vid_sw_r[4];
    assign AN1        = vid_sw_r[5];
    assign AN2        = vid_sw_r[6];
    assign AN3        = vid_sw_r[7];

    assign STORE80    = iie_sw_r[0];
    assign RAMRD      = iie_sw_r[1];
    assign RAMWRT     = iie_sw_r[2];
    assign INTCXROM   = iie_sw_r[3];
    assign ALTZP      = iie_sw_r[4];
    assign SLOTC3ROM  = iie_sw_r[5];
    assign COL80      = iie_sw_r[6];
    assign ALTCHAR    = iie_sw_r[7];

    assign INTC8ROM               = intc8_r;
    assign SLOTROM                = slotrom_r;
    assign TEXT_COLOR             = text_color_r;
    assign BACKGROUND_COLOR       = bg_color_r;
    assign BORDER_COLOR           = border_color_r;
    assign MONOCHROME_MODE        = mono_r;
    assign MONOCHROME_DHIRES_MODE = mono_dhr_r;
    assign SHRG_MODE              = shrg_r;
    assign LINEARIZE_MODE         = linear_r;
    assign aux_mem                = aux_r;
    assign keycode                = keycode_r;
    assign keypress_strobe        = kstb_r;

endmodule

// File: tb/tb_a2mem_switch_snoop.sv
// Directed bench for a2mem_switch_snoop: drives bus cycles on the falling edge and checks the
// registered outputs on the following falling edge against hand-computed values.
module tb_a2mem_switch_snoop;

    logic        clk_logic;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        data_strobe;

    logic TEXT_MODE, MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3;
    logic STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR;
    logic       INTC8ROM;
    logic [2:0] SLOTROM;
    logic [3:0] TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR;
    logic MONOCHROME_MODE, MONOCHROME_DHIRES_MODE, SHRG_MODE, LINEARIZE_MODE;
    logic       aux_mem;
    logic [7:0] keycode;
    logic       keypress_strobe;

    int errors = 0;
    int checks = 0;

    a2mem_switch_snoop #(.ENABLE_IIE(1'b1), .ENABLE_IIGS(1'b1)) dut (
        .clk_logic(clk_logic), .reset(reset), .addr(addr), .data(data), .rw_n(rw_n),
        .data_strobe(data_strobe),
        .TEXT_MODE(TEXT_MODE), .MIXED_MODE(MIXED_MODE), .PAGE2(PAGE2), .HIRES_MODE(HIRES_MODE),
        .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
        .STORE80(STORE80), .RAMRD(RAMRD), .RAMWRT(RAMWRT), .INTCXROM(INTCXROM),
        .ALTZP(ALTZP), .SLOTC3ROM(SLOTC3ROM), .COL80(COL80), .ALTCHAR(ALTCHAR),
        .INTC8ROM(INTC8ROM), .SLOTROM(SLOTROM),
        .TEXT_COLOR(TEXT_COLOR), .BACKGROUND_COLOR(BACKGROUND_COLOR), .BORDER_COLOR(BORDER_COLOR),
        .MONOCHROME_MODE(MONOCHROME_MODE), .MONOCHROME_DHIRES_MODE(MONOCHROME_DHIRES_MODE),
        .SHRG_MODE(SHRG_MODE), .LINEARIZE_MODE(LINEARIZE_MODE),
        .aux_mem(aux_mem), .keycode(keycode), .keypress_strobe(keypress_strobe)
    );

    initial clk_logic = 1'b0;
    always #5 clk_logic = ~clk_logic;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One strobed bus cycle; returns on the falling edge after the capturing rising edge.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rd);
        @(negedge clk_logic);
        addr        = a;
        data        = d;
        rw_n        = rd;
        data_strobe = 1'b1;
        @(negedge clk_logic);
        data_strobe = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        logic [31:0] others;
        others = {MIXED_MODE, PAGE2, HIRES_MODE, AN0, AN1, AN2, AN3,
                  STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
                  INTC8ROM, SLOTROM, MONOCHROME_MODE, MONOCHROME_DHIRES_MODE, SHRG_MODE,
                  LINEARIZE_MODE, aux_mem, keypress_strobe};
        chk({tag, "_text"}, {31'd0, TEXT_MODE}, 32'd1);
        chk({tag, "_colors"}, {20'd0, TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR}, 32'h0000_0F66);
        chk({tag, "_keycode"}, {24'd0, keycode}, 32'd0);
        chk({tag, "_others"}, others, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        addr        = 16'h0000;
        data        = 8'h00;
        rw_n        = 1'b1;
        data_strobe = 1'b0;
        repeat (3) @(negedge clk_logic);
        reset = 1'b0;
        check_reset_values("reset");
        repeat (4) @(negedge clk_logic);
        check_reset_values("idle");

        // Video switches, including back-to-back strobes.
        bus(16'hC055, 8'h00, 1'b1);
        chk("page2_set", {31'd0, PAGE2}, 32'd1);
        @(negedge clk_logic);
        addr = 16'hC057; data = 8'h00; rw_n = 1'b1; data_strobe = 1'b1;
        @(negedge clk_logic);
        chk("b2b_hires_set", {30'd0, HIRES_MODE, PAGE2}, 32'b11);
        addr = 16'hC054;
        @(negedge clk_logic);
        data_strobe = 1'b0;
        chk("b2b_page2_clr", {30'd0, HIRES_MODE, PAGE2}, 32'b10);
        bus(16'hC050, 8'h00, 1'b0);
        chk("text_clr_write", {31'd0, TEXT_MODE}, 32'd0);

        // ][e switches: writes only.
        bus(16'hC001, 8'h00, 1'b0);
        chk("store80_set", {31'd0, STORE80}, 32'd1);
        bus(16'hC001, 8'h00, 1'b1);
        bus(16'hC003, 8'h00, 1'b1);
        chk("iie_read_noop", {30'd0, STORE80, RAMRD}, 32'b10);

        // aux_mem classification.
        bus(16'hC055, 8'h00, 1'b1);
        bus(16'h0400, 8'h00, 1'b0);
        chk("aux_page1_store80", {31'd0, aux_mem}, 32'd1);
        bus(16'h0900, 8'h00, 1'b1);
        chk("aux_main_read", {31'd0, aux_mem}, 32'd0);
        bus(16'h2000, 8'h00, 1'b1);
        chk("aux_hires_store80", {31'd0, aux_mem}, 32'd1);
        bus(16'hC005, 8'h00, 1'b0);
        chk("aux_io_zero", {31'd0, aux_mem, RAMWRT}, 32'b01);
        bus(16'h0900, 8'h00, 1'b0);
        chk("aux_ramwrt", {31'd0, aux_mem}, 32'd1);
        bus(16'h01FF, 8'h00, 1'b1);
        chk("aux_zp_main", {31'd0, aux_mem}, 32'd0);
        bus(16'hC009, 8'h00, 1'b0);
        bus(16'h0100, 8'h00, 1'b1);
        chk("aux_altzp", {31'd0, aux_mem}, 32'd1);

        // Keyboard latch and keypress pulse.
        bus(16'hC000, 8'h41, 1'b1);
        chk("kbd_41", {23'd0, keycode, keypress_strobe}, {23'd0, 8'h41, 1'b0});
        bus(16'hC000, 8'hC1, 1'b1);
        chk("kbd_press", {23'd0, keycode, keypress_strobe}, {23'd0, 8'hC1, 1'b1});
        @(negedge clk_logic);
        chk("kbd_pulse_end", {31'd0, keypress_strobe}, 32'd0);
        bus(16'hC000, 8'hC1, 1'b1);
        chk("kbd_repeat", {23'd0, keycode, keypress_strobe}, {23'd0, 8'hC1, 1'b0});
        chk("kbd_read_keeps_store80", {31'd0, STORE80}, 32'd1);
        bus(16'hC010, 8'h00, 1'b1);
        chk("kbd_clear", {24'd0, keycode}, 32'h41);

        // Slot ROM ownership.
        bus(16'hC600, 8'h00, 1'b1);
        chk("slot6", {28'd0, INTC8ROM, SLOTROM}, {28'd0, 1'b0, 3'd6});
        bus(16'hC300, 8'h00, 1'b1);
        chk("slot3_intc8", {28'd0, INTC8ROM, SLOTROM}, {28'd0, 1'b1, 3'd6});
        bus(16'hC500, 8'h00, 1'b1);
        chk("slot5_blocked", {28'd0, INTC8ROM, SLOTROM}, {28'd0, 1'b1, 3'd6});
        bus(16'hCFFF, 8'h00, 1'b0);
        chk("cfff_release", {28'd0, INTC8ROM, SLOTROM}, 32'd0);
        bus(16'hC5A0, 8'h00, 1'b1);
        chk("slot5_after", {28'd0, INTC8ROM, SLOTROM}, {28'd0, 1'b0, 3'd5});

        // IIgs registers.
        bus(16'hC022, 8'h2E, 1'b0);
        bus(16'hC034, 8'h05, 1'b0);
        bus(16'hC029, 8'hC0, 1'b0);
        chk("gs_colors", {20'd0, TEXT_COLOR, BACKGROUND_COLOR, BORDER_COLOR}, 32'h0000_02E5);
        chk("gs_newvideo", {29'd0, SHRG_MODE, LINEARIZE_MODE, MONOCHROME_DHIRES_MODE}, 32'b110);
        bus(16'hC021, 8'h80, 1'b0);
        chk("gs_mono", {31'd0, MONOCHROME_MODE}, 32'd1);
        bus(16'hC022, 8'hFF, 1'b1);
        chk("gs_read_noop", {28'd0, TEXT_COLOR}, 32'h2);

        // Reset coincident with a strobe.
        @(negedge clk_logic);
        reset = 1'b1;
        addr = 16'hC034; data = 8'h0A; rw_n = 1'b0; data_strobe = 1'b1;
        @(negedge clk_logic);
        data_strobe = 1'b0;
        reset = 1'b0;
        check_reset_values("reset_strobe");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
